exception_ctrl: RTL and testbench

//  Exception/interrupt arbiter upstream of CP0. Collects exception requests from the ID, EXE and MEM

---
 rtl/exception_ctrl_pkg.sv | 39 +++
 rtl/exception_ctrl_if.sv | 59 +++++
 rtl/exc_prio_enc.sv | 66 ++++++
 rtl/exception_ctrl.sv | 149 ++++++++++++++
 tb/tb_exception_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/exception_ctrl_pkg.sv
// rtl/exception_ctrl_pkg.sv - shared ExcCodes, CP0 bit indices, FSM encoding and flush masks
package exception_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int STA_IE     = 0;
    localparam int STA_EXL    = 1;
    localparam int STA_IM_LO  = 8;
    localparam int STA_IM_HI  = 15;

    localparam int CAU_EXC_LO = 2;
    localparam int CAU_EXC_HI = 6;
    localparam int CAU_IP_LO  = 10;
    localparam int CAU_IP_HI  = 15;
    localparam int CAU_BD     = 31;

    // flush mask bit order is {if, id, exe, mem}
    localparam logic [3:0] FLUSH_MEM_FAULT = 4'b1111;
    localparam logic [3:0] FLUSH_EXE_FAULT = 4'b1110;
    localparam logic [3:0] FLUSH_ID_FAULT  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TAKE  = 2'd1,
        ST_ERET  = 2'd2,
        ST_BLOCK = 2'd3
    } state_t;

    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic ds);
        return ds ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - pipeline/CP0 side signal bundle of the exception controller
interface exception_ctrl_if;
    logic [31:0] id_pc;
    logic        id_ds;
    logic        id_sys;
    logic        id_brk;
    logic        id_ri;
    logic        id_eret;
    logic [31:0] exe_pc;
    logic        exe_ds;
    logic        exe_ov;
    logic [31:0] mem_pc;
    logic        mem_ds;
    logic        mem_adel;
    logic        mem_ades;
    logic [31:0] mem_addr;
    logic [5:0]  hw_int;
    logic [31:0] status_cur;
    logic [31:0] cause_cur;
    logic [31:0] epc_cur;

    logic        stall;
    logic        write_sta;
    logic        write_cau;
    logic        write_epc;
    logic        write_bad;
    logic [31:0] status_wr;
    logic [31:0] cause_wr;
    logic [31:0] epc_wr;
    logic [31:0] bad_wr;
    logic        if_flush;
    logic        id_flush;
    logic        exe_flush;
    logic        mem_flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;

    modport master (
        output id_pc, id_ds, id_sys, id_brk, id_ri, id_eret,
        output exe_pc, exe_ds, exe_ov,
        output mem_pc, mem_ds, mem_adel, mem_ades, mem_addr,
        output hw_int, status_cur, cause_cur, epc_cur,
        input  stall, write_sta, write_cau, write_epc, write_bad,
        input  status_wr, cause_wr, epc_wr, bad_wr,
        input  if_flush, id_flush, exe_flush, mem_flush,
        input  pc_redirect, redirect_pc
    );

    modport slave (
        input  id_pc, id_ds, id_sys, id_brk, id_ri, id_eret,
        input  exe_pc, exe_ds, exe_ov,
        input  mem_pc, mem_ds, mem_adel, mem_ades, mem_addr,
        input  hw_int, status_cur, cause_cur, epc_cur,
        output stall, write_sta, write_cau, write_epc, write_bad,
        output status_wr, cause_wr, epc_wr, bad_wr,
        output if_flush, id_flush, exe_flush, mem_flush,
        output pc_redirect, redirect_pc
    );
endinterface

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - picks the oldest pending exception; ERET only wins when nothing else is pending
module exc_prio_enc
    import exception_ctrl_pkg::*;
(
    input  logic [31:0] i_id_pc,
    input  logic        i_id_ds,
    input  logic        i_id_sys,
    input  logic        i_id_brk,
    input  logic        i_id_ri,
    input  logic        i_id_eret,
    input  logic [31:0] i_exe_pc,
    input  logic        i_exe_ds,
    input  logic        i_exe_ov,
    input  logic [31:0] i_mem_pc,
    input  logic        i_mem_ds,
    input  logic        i_mem_adel,
    input  logic        i_mem_ades,
    input  logic [5:0]  i_hw_int,
    input  logic [5:0]  i_im,
    input  logic        i_ie,
    input  logic        i_exl,
    output logic        o_exc,
    output logic        o_eret,
    output logic [4:0]  o_code,
    output logic [31:0] o_pc,
    output logic        o_ds,
    output logic [3:0]  o_flush,
    output logic        o_bad
);
    logic w_int_pend;

    assign w_int_pend = (|(i_hw_int & i_im)) & i_ie & ~i_exl;

    always_comb begin
        o_exc   = 1'b1;
        o_eret  = 1'b0;
        o_code  = EXC_INT;
        o_pc    = i_id_pc;
        o_ds    = i_id_ds;
        o_flush = FLUSH_ID_FAULT;
        o_bad   = 1'b0;
        if (i_mem_adel || i_mem_ades) begin
            o_code  = i_mem_adel ? EXC_ADEL : EXC_ADES;
            o_pc    = i_mem_pc;
            o_ds    = i_mem_ds;
            o_flush = FLUSH_MEM_FAULT;
            o_bad   = 1'b1;
        end else if (i_exe_ov) begin
            o_code  = EXC_OV;
            o_pc    = i_exe_pc;
            o_ds    = i_exe_ds;
            o_flush = FLUSH_EXE_FAULT;
        end else if (i_id_ri) begin
            o_code = EXC_RI;
        end else if (i_id_sys) begin
            o_code = EXC_SYS;
        end else if (i_id_brk) begin
            o_code = EXC_BP;
        end else if (w_int_pend) begin
            o_code = EXC_INT;
        end else begin
            o_exc  = 1'b0;
            o_eret = i_id_eret;
        end
    end
endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception/interrupt arbiter producing CP0 writes, flushes and PC redirect
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          BLOCK_CYC  = 2
) (
    input  logic            clk,
    input  logic            reset,
    exception_ctrl_if.slave bus
);
    state_t      r_state;
    logic [7:0]  r_blk;
    logic        r_write_sta, r_write_cau, r_write_epc, r_write_bad;
    logic [31:0] r_status_wr, r_cause_wr, r_epc_wr, r_bad_wr;
    logic [3:0]  r_flush;
    logic        r_pc_redirect;
    logic [31:0] r_redirect_pc;

    logic        w_exc, w_eret, w_ds, w_bad;
    logic [4:0]  w_code;
    logic [31:0] w_pc, w_cause;
    logic [3:0]  w_flush;
    logic        w_exl;

    exc_prio_enc u_prio (
        .i_id_pc    (bus.id_pc),
        .i_id_ds    (bus.id_ds),
        .i_id_sys   (bus.id_sys),
        .i_id_brk   (bus.id_brk),
        .i_id_ri    (bus.id_ri),
        .i_id_eret  (bus.id_eret),
        .i_exe_pc   (bus.exe_pc),
        .i_exe_ds   (bus.exe_ds),
        .i_exe_ov   (bus.exe_ov),
        .i_mem_pc   (bus.mem_pc),
        .i_mem_ds   (bus.mem_ds),
        .i_mem_adel (bus.mem_adel),
        .i_mem_ades (bus.mem_ades),
        .i_hw_int   (bus.hw_int),
        .i_im       (bus.status_cur[STA_IM_HI:STA_IM_LO+2]),
        .i_ie       (bus.status_cur[STA_IE]),
        .i_exl      (bus.status_cur[STA_EXL]),
        .o_exc      (w_exc),
        .o_eret     (w_eret),
        .o_code     (w_code),
        .o_pc       (w_pc),
        .o_ds       (w_ds),
        .o_flush    (w_flush),
        .o_bad      (w_bad)
    );

    assign w_exl = bus.status_cur[STA_EXL];

    // a nested exception (EXL already set) must keep the original BD alongside the untouched EPC
    always_comb begin
        w_cause                        = bus.cause_cur;
        w_cause[CAU_EXC_HI:CAU_EXC_LO] = w_code;
        w_cause[CAU_IP_HI:CAU_IP_LO]   = bus.hw_int;
        if (!w_exl) begin
            w_cause[CAU_BD] = w_ds;
        end
    end

    assign bus.stall = ~reset && (r_state == ST_IDLE) && (w_exc || w_eret);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_blk         <= 8'd0;
            r_write_sta   <= 1'b0;
            r_write_cau   <= 1'b0;
            r_write_epc   <= 1'b0;
            r_write_bad   <= 1'b0;
            r_status_wr   <= 32'd0;
            r_cause_wr    <= 32'd0;
            r_epc_wr      <= 32'd0;
            r_bad_wr      <= 32'd0;
            r_flush       <= 4'd0;
            r_pc_redirect <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_write_sta   <= 1'b0;
            r_write_cau   <= 1'b0;
            r_write_epc   <= 1'b0;
            r_write_bad   <= 1'b0;
            r_status_wr   <= 32'd0;
            r_cause_wr    <= 32'd0;
            r_epc_wr      <= 32'd0;
            r_bad_wr      <= 32'd0;
            r_flush       <= 4'd0;
            r_pc_redirect <= 1'b0;
            r_redirect_pc <= 32'd0;
            case (r_state)
                ST_IDLE: begin
                    // outputs are computed here so they appear registered in the TAKE/ERET cycle
                    if (w_exc) begin
                        r_state       <= ST_TAKE;
                        r_write_sta   <= 1'b1;
                        r_status_wr   <= bus.status_cur | 32'h2;
                        r_write_cau   <= 1'b1;
                        r_cause_wr    <= w_cause;
                        r_write_epc   <= ~w_exl;
                        r_epc_wr      <= w_exl ? 32'd0 : epc_of(w_pc, w_ds);
                        r_write_bad   <= w_bad;
                        r_bad_wr      <= w_bad ? bus.mem_addr : 32'd0;
                        r_flush       <= w_flush;
                        r_pc_redirect <= 1'b1;
                        r_redirect_pc <= EXC_VECTOR;
                    end else if (w_eret) begin
                        r_state       <= ST_ERET;
                        r_write_sta   <= 1'b1;
                        r_status_wr   <= bus.status_cur & ~32'h2;
                        r_flush       <= FLUSH_ID_FAULT;
                        r_pc_redirect <= 1'b1;
                        r_redirect_pc <= bus.epc_cur;
                    end
                end
                ST_TAKE, ST_ERET: begin
                    r_state <= ST_BLOCK;
                    r_blk   <= 8'(BLOCK_CYC - 1);
                end
                ST_BLOCK: begin
                    if (r_blk == 8'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_blk <= r_blk - 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.write_sta   = r_write_sta;
    assign bus.write_cau   = r_write_cau;
    assign bus.write_epc   = r_write_epc;
    assign bus.write_bad   = r_write_bad;
    assign bus.status_wr   = r_status_wr;
    assign bus.cause_wr    = r_cause_wr;
    assign bus.epc_wr      = r_epc_wr;
    assign bus.bad_wr      = r_bad_wr;
    assign bus.if_flush    = r_flush[3];
    assign bus.id_flush    = r_flush[2];
    assign bus.exe_flush   = r_flush[1];
    assign bus.mem_flush   = r_flush[0];
    assign bus.pc_redirect = r_pc_redirect;
    assign bus.redirect_pc = r_redirect_pc;
endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed scoreboard bench for exception_ctrl
module tb_exception_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    exception_ctrl_if bus ();

    exception_ctrl #(.EXC_VECTOR(32'hBFC00380), .BLOCK_CYC(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [3:0]  w;
        logic [31:0] sta, cau, epc, bad, rpc;
        logic [3:0]  fl;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exc(input string tag, input logic [4:0] code, input logic [31:0] pc,
                                    input logic ds, input logic [31:0] st, input logic [31:0] ca,
                                    input logic [5:0] hw, input logic [3:0] fl, input logic bad_en,
                                    input logic [31:0] addr);
        exp_t e;
        e.tag = tag;
        e.w   = {1'b1, 1'b1, ~st[1], bad_en};
        e.sta = st | 32'h2;
        e.cau = {(st[1] ? ca[31] : ds), ca[30:16], hw, ca[9:7], code, ca[1:0]};
        e.epc = ds ? pc - 32'd4 : pc;
        e.bad = addr;
        e.rpc = 32'hBFC00380;
        e.fl  = fl;
        return e;
    endfunction

    task automatic clear_req();
        bus.id_sys = 0; bus.id_brk = 0; bus.id_ri = 0; bus.id_eret = 0;
        bus.exe_ov = 0; bus.mem_adel = 0; bus.mem_ades = 0; bus.hw_int = 6'd0;
        bus.id_ds = 0; bus.exe_ds = 0; bus.mem_ds = 0;
    endtask

    function automatic logic [31:0] out_or();
        return {bus.write_sta, bus.write_cau, bus.write_epc, bus.write_bad,
                bus.if_flush, bus.id_flush, bus.exe_flush, bus.mem_flush,
                bus.pc_redirect, bus.stall} | bus.status_wr | bus.cause_wr
               | bus.epc_wr | bus.bad_wr | bus.redirect_pc;
    endfunction

    // called right after a request is driven: checks stall, releases the request, then pops on redirect
    task automatic expect_take();
        exp_t e;
        bit   found = 0;
        @(negedge clk);
        chk("stall_detect", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        clear_req();
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            if (bus.pc_redirect) found = 1;
        end
        e = sb.pop_front();
        if (!found) begin
            chk({e.tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({e.tag, "_strobes"}, {28'd0, bus.write_sta, bus.write_cau, bus.write_epc, bus.write_bad}, {28'd0, e.w});
            if (e.w[3]) chk({e.tag, "_status_wr"}, bus.status_wr, e.sta);
            if (e.w[2]) chk({e.tag, "_cause_wr"}, bus.cause_wr, e.cau);
            if (e.w[1]) chk({e.tag, "_epc_wr"}, bus.epc_wr, e.epc);
            if (e.w[0]) chk({e.tag, "_bad_wr"}, bus.bad_wr, e.bad);
            chk({e.tag, "_flush"}, {28'd0, bus.if_flush, bus.id_flush, bus.exe_flush, bus.mem_flush}, {28'd0, e.fl});
            chk({e.tag, "_redirect_pc"}, bus.redirect_pc, e.rpc);
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   seen;
        clear_req();
        bus.id_pc = 0; bus.exe_pc = 0; bus.mem_pc = 0; bus.mem_addr = 0;
        bus.status_cur = 0; bus.cause_cur = 0; bus.epc_cur = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_held_outputs", out_or(), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_idle_outputs", out_or(), 32'd0);
        @(posedge clk); #1;

        // 1: overflow in EXE
        bus.exe_ov = 1; bus.exe_pc = 32'h80001000; bus.status_cur = 0; bus.cause_cur = 0;
        sb.push_back(mk_exc("ov", 5'h0C, 32'h80001000, 0, 0, 0, 6'd0, 4'b1110, 0, 0));
        expect_take(); settle();

        // 2: AdEL beats a simultaneous overflow
        bus.mem_adel = 1; bus.mem_pc = 32'h80002000; bus.mem_addr = 32'h3;
        bus.exe_ov = 1; bus.exe_pc = 32'h80001FFC;
        sb.push_back(mk_exc("adel", 5'h04, 32'h80002000, 0, 0, 0, 6'd0, 4'b1111, 1, 32'h3));
        expect_take(); settle();

        // AdES beats an ID syscall
        bus.mem_ades = 1; bus.mem_pc = 32'h80003000; bus.mem_addr = 32'h80004001;
        bus.id_sys = 1; bus.id_pc = 32'h80003008;
        sb.push_back(mk_exc("ades", 5'h05, 32'h80003000, 0, 0, 0, 6'd0, 4'b1111, 1, 32'h80004001));
        expect_take(); settle();

        // 3: syscall in a delay slot
        bus.id_sys = 1; bus.id_ds = 1; bus.id_pc = 32'h80000104;
        sb.push_back(mk_exc("sys_ds", 5'h08, 32'h80000104, 1, 0, 0, 6'd0, 4'b1100, 0, 0));
        expect_take(); settle();

        // break in a delay slot at PC 0: EPC wraps
        bus.id_brk = 1; bus.id_ds = 1; bus.id_pc = 32'h0;
        sb.push_back(mk_exc("brk_wrap", 5'h09, 32'h0, 1, 0, 0, 6'd0, 4'b1100, 0, 0));
        expect_take(); settle();

        // RI beats syscall; EXL already set so EPC/BD untouched
        bus.id_ri = 1; bus.id_sys = 1; bus.id_ds = 1; bus.id_pc = 32'h80000500;
        bus.status_cur = 32'h2; bus.cause_cur = 32'h8000_0000;
        sb.push_back(mk_exc("ri_exl", 5'h0A, 32'h80000500, 1, 32'h2, 32'h8000_0000, 6'd0, 4'b1100, 0, 0));
        expect_take(); settle();

        // 4: hardware interrupt enabled
        bus.hw_int = 6'b000001; bus.id_pc = 32'h80000300; bus.status_cur = 32'h0401; bus.cause_cur = 0;
        sb.push_back(mk_exc("int", 5'h00, 32'h80000300, 0, 32'h0401, 0, 6'b000001, 4'b1100, 0, 0));
        expect_take(); settle();

        // 4b: same interrupt with EXL set is not taken
        bus.hw_int = 6'b000001; bus.status_cur = 32'h0403;
        @(negedge clk);
        chk("int_exl_stall", {31'd0, bus.stall}, 32'd0);
        seen = 0;
        repeat (4) begin @(negedge clk); if (bus.pc_redirect) seen++; end
        chk("int_exl_no_redirect", seen, 32'd0);
        @(posedge clk); #1; clear_req();

        // 5: ERET
        bus.id_eret = 1; bus.epc_cur = 32'h80000200; bus.status_cur = 32'h2;
        e.tag = "eret"; e.w = 4'b1000; e.sta = 32'h0; e.cau = 0; e.epc = 0; e.bad = 0;
        e.rpc = 32'h80000200; e.fl = 4'b1100;
        sb.push_back(e);
        expect_take(); settle();

        // ERET dropped in favour of a simultaneous overflow
        bus.id_eret = 1; bus.exe_ov = 1; bus.exe_pc = 32'h80000600; bus.status_cur = 0;
        sb.push_back(mk_exc("eret_vs_ov", 5'h0C, 32'h80000600, 0, 0, 0, 6'd0, 4'b1110, 0, 0));
        expect_take(); settle();

        // 6: reset during TAKE clears everything at the next edge
        bus.exe_ov = 1; bus.exe_pc = 32'h80001000;
        sb.push_back(mk_exc("ov_pre_rst", 5'h0C, 32'h80001000, 0, 0, 0, 6'd0, 4'b1110, 0, 0));
        expect_take();
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_in_take", out_or(), 32'd0);
        seen = 0;
        repeat (3) begin @(negedge clk); if (bus.pc_redirect) seen++; end
        chk("reset_no_redirect", seen, 32'd0);
        @(posedge clk); #1;

        // request raised for one cycle during BLOCK is ignored
        bus.id_sys = 1; bus.id_pc = 32'h80000700;
        sb.push_back(mk_exc("sys_pre_blk", 5'h08, 32'h80000700, 0, 0, 0, 6'd0, 4'b1100, 0, 0));
        expect_take();
        @(posedge clk); #1;
        bus.id_sys = 1;
        @(negedge clk);
        chk("block_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1; clear_req();
        seen = 0;
        repeat (5) begin @(negedge clk); if (bus.pc_redirect || bus.stall) seen++; end
        chk("block_ignored", seen, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
